gzip_trailer_checker: RTL and testbench

//  Receive-side integrity checker for GZIP members (RFC 1952), the decompressor-side companion of the CRC-32 generator.

---
 rtl/gzip_pkg.sv | 28 ++
 rtl/crc32_byte_step.sv | 23 ++
 rtl/gzip_trailer_checker.sv | 144 ++++++++++++++
 tb/tb_gzip_trailer_checker.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gzip_pkg.sv
// Shared constants, state encoding and CRC-32 table generator for the GZIP
// member generator/checker pair.
package gzip_pkg;

  localparam logic [31:0] CRC32_INIT         = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY_REFL    = 32'hEDB8_8320;
  localparam int          GZIP_TRAILER_BYTES = 8;

  // Member-level state of the trailer checker
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_TRAILER = 2'd2,
    ST_DONE    = 2'd3
  } gzip_state_e;

  // One entry of the reflected byte-wise CRC-32 table: eight bit-serial
  // steps starting from the table index.
  function automatic logic [31:0] crc32_lut_entry(input logic [7:0] idx);
    logic [31:0] c;
    c = {24'd0, idx};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational one-byte CRC-32 update (reflected form). The 256-entry table
// is built from the polynomial at elaboration time, so it folds to constants.
module crc32_byte_step
  import gzip_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] lut [256];

  genvar gi;
  generate
    for (gi = 0; gi < 256; gi++) begin : g_lut
      assign lut[gi] = crc32_lut_entry(8'(gi));
    end
  endgenerate

  // Table-driven step: shift out the low byte, fold in the table entry
  assign crc_next = (crc >> 8) ^ lut[crc[7:0] ^ data];

endmodule

// File: rtl/gzip_trailer_checker.sv
// Receive-side GZIP member checker: accumulates CRC-32 and ISIZE over the
// payload, captures the 8-byte little-endian trailer and reports a
// pass/fail verdict with a one-cycle done pulse per member.
module gzip_trailer_checker
  import gzip_pkg::*;
#(
  parameter bit CHECK_SIZE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_is_trl,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic        size_ok,
  output logic        err_proto,
  output logic [31:0] crc_calc,
  output logic [31:0] size_calc
);

  gzip_state_e state_reg, state_next;

  logic [31:0] crc_acc_reg;
  logic [31:0] size_cnt_reg;
  logic [63:0] trl_sr_reg;
  logic [2:0]  trl_cnt_reg;

  logic        crc_ok_reg, size_ok_reg, err_proto_reg;
  logic [31:0] crc_calc_reg, size_calc_reg;

  logic [31:0] crc_step;
  logic [63:0] trl_sr_next;
  logic        accept, pay_acc, trl_acc;
  logic        last_trl, proto_err, enter_done;
  logic        size_match;

  crc32_byte_step u_crc_step (
    .crc      (crc_acc_reg),
    .data     (in_data),
    .crc_next (crc_step)
  );

  // Only the DONE cycle refuses input; kept apart from the FSM block so
  // accept never loops back through next-state logic.
  assign in_ready = (state_reg != ST_DONE);

  assign accept     = in_valid & in_ready;
  assign pay_acc    = accept & ~in_is_trl;
  assign trl_acc    = accept & in_is_trl;
  assign last_trl   = trl_acc & (state_reg == ST_TRAILER)
                    & (trl_cnt_reg == 3'(GZIP_TRAILER_BYTES - 1));
  assign proto_err  = pay_acc & (state_reg == ST_TRAILER);
  assign enter_done = last_trl | proto_err;

  // Trailer register as it will look after the current byte lands, so the
  // verdict can be formed on the same edge as the last trailer byte.
  always_comb begin
    trl_sr_next = trl_sr_reg;
    if (trl_acc) begin
      trl_sr_next[{trl_cnt_reg, 3'b000} +: 8] = in_data;
    end
  end

  assign size_match = CHECK_SIZE ? (size_cnt_reg == trl_sr_next[63:32]) : 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and status outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pay_acc)      state_next = ST_DATA;
        else if (trl_acc) state_next = ST_TRAILER;
      end
      ST_DATA: begin
        busy = 1'b1;
        if (trl_acc) state_next = ST_TRAILER;
      end
      ST_TRAILER: begin
        busy = 1'b1;
        if (enter_done) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Accumulators, trailer capture and result registers. The verdict is
  // latched on entry to DONE and the accumulators restart on the same edge,
  // which is safe because nothing is accepted during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_acc_reg   <= CRC32_INIT;
      size_cnt_reg  <= 32'd0;
      trl_sr_reg    <= 64'd0;
      trl_cnt_reg   <= 3'd0;
      crc_ok_reg    <= 1'b0;
      size_ok_reg   <= 1'b0;
      err_proto_reg <= 1'b0;
      crc_calc_reg  <= 32'd0;
      size_calc_reg <= 32'd0;
    end else if (enter_done) begin
      // A stray payload byte inside the trailer is dropped, not hashed
      crc_calc_reg  <= ~crc_acc_reg;
      size_calc_reg <= size_cnt_reg;
      crc_ok_reg    <= ~proto_err & (~crc_acc_reg == trl_sr_next[31:0]);
      size_ok_reg   <= ~proto_err & size_match;
      err_proto_reg <= proto_err;
      trl_sr_reg    <= trl_sr_next;
      crc_acc_reg   <= CRC32_INIT;
      size_cnt_reg  <= 32'd0;
      trl_cnt_reg   <= 3'd0;
    end else if (pay_acc) begin
      crc_acc_reg  <= crc_step;
      size_cnt_reg <= size_cnt_reg + 32'd1;
    end else if (trl_acc) begin
      trl_sr_reg  <= trl_sr_next;
      trl_cnt_reg <= trl_cnt_reg + 3'd1;
    end
  end

  assign crc_ok    = crc_ok_reg;
  assign size_ok   = size_ok_reg;
  assign err_proto = err_proto_reg;
  assign crc_calc  = crc_calc_reg;
  assign size_calc = size_calc_reg;

endmodule

// File: tb/tb_gzip_trailer_checker.sv
// Directed bench for gzip_trailer_checker: known CRC-32 vectors, empty member,
// corrupted CRC/ISIZE, valid gaps with back-to-back members, protocol error
// and reset in the middle of a member.
module tb_gzip_trailer_checker;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_is_trl;
  logic        in_valid;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        size_ok;
  logic        err_proto;
  logic [31:0] crc_calc;
  logic [31:0] size_calc;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [7:0] pay [16];
  logic [7:0] trl [8];

  gzip_trailer_checker #(.CHECK_SIZE(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_is_trl (in_is_trl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok),
    .size_ok   (size_ok),
    .err_proto (err_proto),
    .crc_calc  (crc_calc),
    .size_calc (size_calc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which done is seen high
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Present one byte and hold it until it is accepted (bounded wait)
  task automatic send(input logic [7:0] d, input logic t);
    int guard;
    guard = 0;
    in_data   = d;
    in_is_trl = t;
    in_valid  = 1'b1;
    while (in_ready !== 1'b1) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 20) begin
        checks++; errors++;
        $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_123456789();
    pay = '{0:8'h31, 1:8'h32, 2:8'h33, 3:8'h34, 4:8'h35, 5:8'h36,
            6:8'h37, 7:8'h38, 8:8'h39, default:8'h00};
    trl = '{8'h26, 8'h39, 8'hF4, 8'hCB, 8'h09, 8'h00, 8'h00, 8'h00};
  endtask

  // Drive n payload bytes then the trailer; report done/in_ready as seen in
  // the cycle after the 8th trailer byte.
  task automatic run_member(input int n, input bit gaps,
                            output logic done_seen, output logic rdy_seen);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send(pay[i], 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send(trl[i], 1'b1);
    end
    done_seen = done;
    rdy_seen  = in_ready;
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, busy, done, crc_ok, size_ok, err_proto} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags got %b required 100000",
               {in_ready, busy, done, crc_ok, size_ok, err_proto});
    end
    checks++;
    if (crc_calc !== 32'd0 || size_calc !== 32'd0) begin
      errors++;
      $display("FAIL reset_results crc=%h size=%h required 0/0", crc_calc, size_calc);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic d, r;
    int c0;
    c0 = done_cnt;
    load_123456789();
    run_member(9, 1'b0, d, r);
    checks++;
    if (d !== 1'b1 || r !== 1'b0) begin
      errors++;
      $display("FAIL basic_done done=%b in_ready=%b required 1/0", d, r);
    end
    checks++;
    if (crc_calc !== 32'hCBF43926 || size_calc !== 32'd9) begin
      errors++;
      $display("FAIL basic_calc crc=%h size=%0d required cbf43926/9", crc_calc, size_calc);
    end
    checks++;
    if ({crc_ok, size_ok, err_proto} !== 3'b110) begin
      errors++;
      $display("FAIL basic_ok got %b required 110", {crc_ok, size_ok, err_proto});
    end
    idle(1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - c0 != 1) begin
      errors++;
      $display("FAIL basic_pulse done=%b busy=%b pulses=%0d required 0/0/1",
               done, busy, done_cnt - c0);
    end
    $display("test_basic crc=%h size=%0d", crc_calc, size_calc);
  endtask

  task automatic test_empty();
    logic d, r;
    trl = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(trl[0], 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL empty_busy got %b required 1", busy);
    end
    for (int i = 1; i < 8; i++) send(trl[i], 1'b1);
    d = done;
    checks++;
    if (d !== 1'b1 || crc_calc !== 32'd0 || size_calc !== 32'd0 ||
        {crc_ok, size_ok, err_proto} !== 3'b110) begin
      errors++;
      $display("FAIL empty_result done=%b crc=%h size=%0d ok=%b required 1/00000000/0/110",
               d, crc_calc, size_calc, {crc_ok, size_ok, err_proto});
    end
    idle(1);
    $display("test_empty crc=%h size=%0d", crc_calc, size_calc);
  endtask

  task automatic test_corrupt();
    logic d, r;
    load_123456789();
    pay[4] = 8'h36;
    run_member(9, 1'b0, d, r);
    checks++;
    if (d !== 1'b1 || {crc_ok, size_ok} !== 2'b01) begin
      errors++;
      $display("FAIL corrupt_crc done=%b ok=%b required 1/01", d, {crc_ok, size_ok});
    end
    checks++;
    if (crc_calc === 32'hCBF43926 || size_calc !== 32'd9) begin
      errors++;
      $display("FAIL corrupt_crc_calc crc=%h size=%0d required !=cbf43926/9", crc_calc, size_calc);
    end
    idle(1);
    load_123456789();
    trl[4] = 8'h0A;
    run_member(9, 1'b0, d, r);
    checks++;
    if (d !== 1'b1 || {crc_ok, size_ok} !== 2'b10 || crc_calc !== 32'hCBF43926) begin
      errors++;
      $display("FAIL corrupt_size done=%b ok=%b crc=%h required 1/10/cbf43926",
               d, {crc_ok, size_ok}, crc_calc);
    end
    idle(1);
    $display("test_corrupt ok=%b", {crc_ok, size_ok});
  endtask

  task automatic test_back_to_back();
    logic d, r;
    int c0;
    c0 = done_cnt;
    load_123456789();
    run_member(9, 1'b1, d, r);
    checks++;
    if (d !== 1'b1 || r !== 1'b0 || {crc_ok, size_ok} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_first done=%b in_ready=%b ok=%b required 1/0/11",
               d, r, {crc_ok, size_ok});
    end
    pay = '{0:8'h61, default:8'h00};
    trl = '{8'h43, 8'hBE, 8'hB7, 8'hE8, 8'h01, 8'h00, 8'h00, 8'h00};
    run_member(1, 1'b0, d, r);
    checks++;
    if (d !== 1'b1 || r !== 1'b0 || crc_calc !== 32'hE8B7BE43 || size_calc !== 32'd1 ||
        {crc_ok, size_ok} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_second done=%b in_ready=%b crc=%h size=%0d ok=%b required 1/0/e8b7be43/1/11",
               d, r, crc_calc, size_calc, {crc_ok, size_ok});
    end
    idle(1);
    checks++;
    if (done_cnt - c0 != 2) begin
      errors++;
      $display("FAIL b2b_pulses got %0d required 2", done_cnt - c0);
    end
    $display("test_back_to_back crc=%h", crc_calc);
  endtask

  task automatic test_proto_err();
    logic d, r;
    load_123456789();
    for (int i = 0; i < 9; i++) send(pay[i], 1'b0);
    for (int i = 0; i < 3; i++) send(trl[i], 1'b1);
    send(8'h55, 1'b0);
    checks++;
    if (done !== 1'b1 || {crc_ok, size_ok, err_proto} !== 3'b001) begin
      errors++;
      $display("FAIL proto_err done=%b ok/err=%b required 1/001", done, {crc_ok, size_ok, err_proto});
    end
    checks++;
    if (crc_calc !== 32'hCBF43926 || size_calc !== 32'd9) begin
      errors++;
      $display("FAIL proto_discard crc=%h size=%0d required cbf43926/9", crc_calc, size_calc);
    end
    idle(1);
    checks++;
    if (err_proto !== 1'b1) begin
      errors++;
      $display("FAIL proto_hold got %b required 1", err_proto);
    end
    run_member(9, 1'b0, d, r);
    checks++;
    if (d !== 1'b1 || {crc_ok, size_ok, err_proto} !== 3'b110) begin
      errors++;
      $display("FAIL proto_clear done=%b ok/err=%b required 1/110", d, {crc_ok, size_ok, err_proto});
    end
    idle(1);
    $display("test_proto_err err=%b", err_proto);
  endtask

  task automatic test_reset_mid();
    logic d, r;
    int c0;
    c0 = done_cnt;
    load_123456789();
    for (int i = 0; i < 5; i++) send(pay[i], 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || crc_calc !== 32'd0 || crc_ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid busy=%b crc=%h ok=%b required 0/0/0", busy, crc_calc, crc_ok);
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    run_member(9, 1'b0, d, r);
    checks++;
    if (d !== 1'b1 || crc_calc !== 32'hCBF43926 || size_calc !== 32'd9 ||
        {crc_ok, size_ok} !== 2'b11) begin
      errors++;
      $display("FAIL reset_replay done=%b crc=%h size=%0d ok=%b required 1/cbf43926/9/11",
               d, crc_calc, size_calc, {crc_ok, size_ok});
    end
    idle(1);
    checks++;
    if (done_cnt - c0 != 1) begin
      errors++;
      $display("FAIL reset_pulses got %0d required 1", done_cnt - c0);
    end
    $display("test_reset_mid crc=%h", crc_calc);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_is_trl = 1'b0;
    in_valid  = 1'b0;
    idle(3);
    test_reset();
    rst_n = 1'b1;
    idle(1);
    test_basic();
    test_empty();
    test_corrupt();
    test_back_to_back();
    test_proto_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required completion", $time);
    $fatal(1);
  end

endmodule
